// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and helpers for the MIPS pipeline queues.
//   MIPS_NOP   : encoding presented to decode when a queue has nothing to offer
//   occ_width  : width of an occupancy counter able to hold 0..depth inclusive
package mips_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // A queue of depth N needs to represent N+1 distinct fill levels.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifid_queue_mem.sv
// ifid_queue_mem
// DEPTH x WIDTH register array holding {pc, instr} pairs for the IF/ID queue.
// Synchronous write, asynchronous read, no reset (contents are don't-care
// until written).
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write slot
//   wdata  : entry to store
//   raddr  : read slot
//   rdata  : entry currently stored at raddr
module ifid_queue_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write port: only the addressed slot is touched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue
// DEPTH-entry in-order queue of {pc, instr} pairs between fetch and decode.
// Fetch keeps pushing while decode stalls until the queue fills; a flush
// empties it in one cycle; decode sees a NOP whenever it is empty.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   flush_i  : discard all stored entries at the next edge
//   push_i   : fetch presents pc_i/instr_i this cycle
//   pc_i     : fetched PC
//   instr_i  : fetched instruction
//   full_o   : queue holds DEPTH entries, fetch must stall
//   pop_i    : decode consumes the head entry this cycle
//   valid_o  : head entry is meaningful
//   pc_o     : head PC, 0 when empty
//   instr_o  : head instruction, NOP_INSTR when empty
//   count_o  : current occupancy
//   drop_o   : one-cycle pulse after a push was refused because the queue was full
module ifid_fetch_queue
    import mips_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 32,
    parameter int                   DEPTH        = 2,
    parameter bit                   FLUSH_ENABLE = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = DATA_WIDTH'(MIPS_NOP)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         pc_i,
    input  logic [DATA_WIDTH-1:0]         instr_i,
    output logic                          full_o,
    input  logic                          pop_i,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         pc_o,
    output logic [DATA_WIDTH-1:0]         instr_o,
    output logic [occ_width(DEPTH)-1:0]   count_o,
    output logic                          drop_o
);

    localparam int CNT_W = occ_width(DEPTH);
    // Keep at least one pointer bit so DEPTH=1 still has a legal vector.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count_q;
    logic                    drop_q;
    logic                    full;
    logic                    empty;
    logic                    flush_eff;
    logic                    push_acc;
    logic                    pop_acc;
    logic [2*DATA_WIDTH-1:0] head;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign flush_eff = FLUSH_ENABLE & flush_i;
    // Acceptance depends only on the registered count: no pass-through when
    // full, so full_o never has a combinational path from pop_i.
    assign push_acc  = push_i & ~full;
    assign pop_acc   = pop_i & ~empty;

    ifid_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_WIDTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc & ~flush_eff),
        .waddr (wr_ptr),
        .wdata ({pc_i, instr_i}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy bookkeeping. A flush wins over a same-cycle push
    // and pop; moving rd_ptr onto wr_ptr empties the queue without touching
    // storage. Pointers wrap by compare so DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_eff) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Refused-push indicator; a push discarded by a flush is not a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= push_i & full & ~flush_eff;
        end
    end

    assign full_o  = full;
    assign valid_o = ~empty;
    assign count_o = count_q;
    assign drop_o  = drop_q;
    assign pc_o    = empty ? '0 : head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign instr_o = empty ? NOP_INSTR : head[DATA_WIDTH-1:0];

endmodule
